// File: rtl/fft_sym_ctrl_pkg.sv
// Shared constants, state encoding and scaling tables for the FFT symbol controller.
// Used by fft_sym_ctrl and fft_cp_cnt; the optional FFT_CTRL_STAT_EN build adds nothing here.
package fft_sym_ctrl_pkg;

  localparam int FFT_NFFT_NBIT = 5;
  localparam int FFT_SCH_NBIT  = 12;
  localparam int FFT_CNT_NBIT  = 12;

  localparam logic [FFT_CNT_NBIT-1:0] CP_BASE_NORM0 = 12'd160;
  localparam logic [FFT_CNT_NBIT-1:0] CP_BASE_NORM  = 12'd144;
  localparam logic [FFT_CNT_NBIT-1:0] CP_BASE_EXT   = 12'd512;
  localparam logic [FFT_CNT_NBIT-1:0] FFT_LEN_MAX   = 12'd2048;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CFG      = 3'd1,
    ST_WAIT_RFD = 3'd2,
    ST_START    = 3'd3,
    ST_LOAD     = 3'd4,
    ST_DRAIN    = 3'd5
  } fft_state_e;

  // Two bits per radix-4 stage; entries 5-7 correspond to illegal sizes and are never loaded.
  localparam logic [FFT_SCH_NBIT-1:0] SCALE_FFT [0:7] = '{
    12'hAAB, 12'h2AA, 12'h0AB, 12'h0AA, 12'h02B, 12'h000, 12'h000, 12'h000
  };
  localparam logic [FFT_SCH_NBIT-1:0] SCALE_IFFT [0:7] = '{
    12'h555, 12'h155, 12'h056, 12'h055, 12'h016, 12'h000, 12'h000, 12'h000
  };

  function automatic logic [FFT_SCH_NBIT-1:0] scale_lookup(input logic       ifft,
                                                            input logic [2:0] num);
    return ifft ? SCALE_IFFT[num] : SCALE_FFT[num];
  endfunction

  function automatic logic num_legal(input logic [2:0] num);
    return (num <= 3'd4);
  endfunction

endpackage

// File: rtl/fft_cp_cnt.sv
// Slot symbol index tracking and cyclic-prefix length derivation for each accepted symbol head.
// Index and cp_len update only on head_stb, so they stay stable for the whole symbol.
module fft_cp_cnt
  import fft_sym_ctrl_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    head_stb,
  input  logic                    din_s,
  input  logic                    cp_type,
  input  logic [2:0]              fft_num,
  output logic                    fst_cp,
  output logic [FFT_CNT_NBIT-1:0] cp_len
);

  logic [2:0]              sym_idx;
  logic [2:0]              idx_nxt;
  logic [2:0]              idx_wrap;
  logic [FFT_CNT_NBIT-1:0] cp_base;

  always_comb begin
    idx_wrap = cp_type ? 3'd5 : 3'd6;
    // ">=" also recovers an index left at 6 when the slot switches to extended CP.
    if (din_s) begin
      idx_nxt = 3'd0;
    end else if (sym_idx >= idx_wrap) begin
      idx_nxt = 3'd0;
    end else begin
      idx_nxt = sym_idx + 3'd1;
    end

    if (cp_type) begin
      cp_base = CP_BASE_EXT;
    end else if (idx_nxt == 3'd0) begin
      cp_base = CP_BASE_NORM0;
    end else begin
      cp_base = CP_BASE_NORM;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sym_idx <= 3'd0;
      fst_cp  <= 1'b0;
      cp_len  <= '0;
    end else if (head_stb) begin
      sym_idx <= idx_nxt;
      fst_cp  <= (idx_nxt == 3'd0);
      cp_len  <= cp_base >> fft_num;
    end
  end

endmodule

// File: rtl/fft_sym_ctrl.sv
// Per-symbol sequencer for a streaming FFT core: configures, starts, loads (flagging CP samples) and unloads.
// Define FFT_CTRL_STAT_EN to add the sym_cnt / ovr_cnt statistics ports.
module fft_sym_ctrl
  import fft_sym_ctrl_pkg::*;
#(
  parameter int BIT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [2:0]               fft_num,
  input  logic                     cp_type,
  input  logic                     fft_type,
  input  logic                     din_h,
  input  logic                     din_s,
  input  logic                     din_v,
  input  logic                     core_rfd,
  input  logic                     core_done,
  output logic [FFT_NFFT_NBIT-1:0] nfft,
  output logic                     nfft_we,
  output logic                     fwd_inv,
  output logic                     fwd_inv_we,
  output logic [FFT_SCH_NBIT-1:0]  scale_sch,
  output logic                     scale_sch_we,
  output logic                     start,
  output logic                     unload,
  output logic                     cp_drop,
  output logic                     fst_cp,
  output logic                     busy,
  output logic                     err
`ifdef FFT_CTRL_STAT_EN
  ,
  output logic [BIT_WIDTH-1:0]     sym_cnt,
  output logic [7:0]               ovr_cnt
`endif
);

  if (BIT_WIDTH < 1) begin : g_bit_width_check
    $error("fft_sym_ctrl: BIT_WIDTH must be at least 1");
  end

  fft_state_e              state;
  fft_state_e              state_nxt;
  logic [FFT_CNT_NBIT-1:0] cnt;
  logic [FFT_CNT_NBIT-1:0] cp_len;
  logic [FFT_CNT_NBIT-1:0] n_len;
  logic [FFT_CNT_NBIT-1:0] last_idx;
  logic [2:0]              cfg_num;
  logic                    head;
  logic                    cfg_ok;
  logic                    last_smp;
  logic                    overrun;
  logic                    head_acc;
  logic                    err_set;
  logic                    unload_nxt;

  assign head     = din_h & din_v;
  assign cfg_ok   = num_legal(fft_num);
  assign n_len    = FFT_LEN_MAX >> cfg_num;
  assign last_idx = cp_len + n_len - 12'd1;
  assign last_smp = din_v & (cnt == last_idx);
  // A head on the final sample simply closes the symbol; earlier heads abort it.
  assign overrun  = (state == ST_LOAD) & head & ~last_smp;

  fft_cp_cnt u_cp_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .head_stb (head_acc),
    .din_s    (din_s),
    .cp_type  (cp_type),
    .fft_num  (fft_num),
    .fst_cp   (fst_cp),
    .cp_len   (cp_len)
  );

  always_comb begin
    state_nxt  = state;
    head_acc   = 1'b0;
    err_set    = 1'b0;
    unload_nxt = 1'b0;
    case (state)
      ST_IDLE: begin
        if (head) begin
          if (cfg_ok) begin
            state_nxt = ST_CFG;
            head_acc  = 1'b1;
          end else begin
            err_set = 1'b1;
          end
        end
      end
      ST_CFG: begin
        state_nxt = ST_WAIT_RFD;
      end
      ST_WAIT_RFD: begin
        err_set = din_h;
        if (core_rfd) begin
          state_nxt = ST_START;
        end
      end
      ST_START: begin
        err_set   = din_h;
        state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        if (overrun) begin
          err_set = 1'b1;
          if (cfg_ok) begin
            state_nxt = ST_CFG;
            head_acc  = 1'b1;
          end else begin
            state_nxt = ST_IDLE;
          end
        end else if (last_smp) begin
          state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        err_set = din_h;
        if (core_done) begin
          state_nxt  = ST_IDLE;
          unload_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Every output is registered from next-state decode, giving one cycle from din_h to nfft_we.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      nfft         <= 5'd11;
      nfft_we      <= 1'b0;
      fwd_inv      <= 1'b1;
      fwd_inv_we   <= 1'b0;
      scale_sch    <= '0;
      scale_sch_we <= 1'b0;
      start        <= 1'b0;
      unload       <= 1'b0;
      cp_drop      <= 1'b0;
      busy         <= 1'b0;
      err          <= 1'b0;
      cfg_num      <= 3'd0;
      cnt          <= '0;
    end else begin
      nfft_we      <= head_acc;
      fwd_inv_we   <= head_acc;
      scale_sch_we <= head_acc;
      if (head_acc) begin
        nfft      <= 5'd11 - {2'b00, fft_num};
        fwd_inv   <= ~fft_type;
        scale_sch <= scale_lookup(fft_type, fft_num);
        cfg_num   <= fft_num;
      end
      start   <= (state_nxt == ST_START);
      unload  <= unload_nxt;
      busy    <= (state_nxt != ST_IDLE) | unload_nxt;
      cp_drop <= (state == ST_LOAD) & din_v & ~overrun & (cnt < cp_len);
      err     <= err | err_set;
      if (state == ST_START) begin
        cnt <= '0;
      end else if ((state == ST_LOAD) && din_v) begin
        cnt <= cnt + 12'd1;
      end
    end
  end

`ifdef FFT_CTRL_STAT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sym_cnt <= '0;
      ovr_cnt <= 8'd0;
    end else begin
      if (unload_nxt) begin
        sym_cnt <= sym_cnt + 1'b1;
      end
      if (overrun && (ovr_cnt != 8'hFF)) begin
        ovr_cnt <= ovr_cnt + 8'd1;
      end
    end
  end
`endif

endmodule
